sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 inst_req / inst_wr / inst_size  input  1/1/2  instruction master: request, write flag, size code (0=byte, 1=half, 2=word).
REQ-006 inst_addr / inst_wdata  input  ADDR_W/DATA_W  instruction master address and write data.
REQ-007 inst_addr_ok / inst_data_ok  output  1/1  instruction master request-accepted pulse and data-done pulse.
REQ-008 inst_rdata  output  DATA_W  instruction master read data.
REQ-009 data_req, data_wr, data_size, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata  same directions and widths as REQ-005..008  data master port.
REQ-010 s_req / s_wr / s_size / s_addr / s_wdata  output  1/1/2/ADDR_W/DATA_W  shared slave request.
REQ-011 s_addr_ok / s_data_ok / s_rdata  input  1/1/DATA_W  shared slave responses.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states: IDLE, REQ, WAIT. Exactly one transaction is outstanding at a time.
REQ-014 IDLE grant rule: data_req=1 grants DATA; else inst_req=1 grants INST; else no grant. Fixed priority, data wins.
REQ-015 On a grant in IDLE, assert the winner's addr_ok combinationally in the same cycle.
REQ-016 On the same grant edge, latch wr, size, addr, wdata and the owner ID; next state is REQ.
REQ-017 The loser's addr_ok SHALL stay 0; the loser holds its req until granted later.
REQ-018 REQ: s_req=1 and s_wr/s_size/s_addr/s_wdata driven from the latches; hold until s_addr_ok=1.
REQ-019 REQ with s_addr_ok=1 and s_data_ok=0: next state WAIT.
REQ-020 REQ with s_addr_ok=1 and s_data_ok=1: complete the transaction in that cycle; next state IDLE.
REQ-021 WAIT: s_req=0; hold until s_data_ok=1; next state IDLE.
REQ-022 On completion, pulse the owner's data_ok for exactly one cycle and pass s_rdata combinationally to the owner's rdata. The non-owner's data_ok SHALL be 0.
REQ-023 s_req SHALL be 0 in IDLE and WAIT; s_data_ok outside WAIT/REQ SHALL be ignored.
REQ-024 Minimum throughput: grant at cycle N, s_req at N+1, earliest completion N+1, next grant N+2.
REQ-025 inst_rdata/data_rdata SHALL be 0 when not completing.
REQ-026 The latched request SHALL NOT change while the state is REQ or WAIT; master inputs are don't-care then.

Reset
REQ-027 resetn=0 asynchronously forces state IDLE and clears the latched request and owner ID.
REQ-028 During reset, every output is 0 (s_req, s_*, all addr_ok/data_ok, rdata, busy).
REQ-029 Reset mid-transaction abandons it; after resetn rises, the arbiter drops any late s_data_ok and raises no data_ok.

Structure
REQ-030 State encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2) and owner IDs (OWN_INST=1'b0, OWN_DATA=1'b1) belong in the shared defines header.
REQ-031 Single module, no sub-modules; the request latch is one enable register of width 1+1+2+ADDR_W+DATA_W plus the owner bit.

Verification
REQ-032 inst_req only, addr 0xBFC00000, slave addr_ok at N+1, data_ok at N+3 with 0x3C1D0001 -> inst_addr_ok at N, s_req N+1..N+1, inst_data_ok pulse at N+3 with inst_rdata=0x3C1D0001.
REQ-033 inst_req and data_req both high, data write to 0x80001000 with 0xDEADBEEF -> data granted first; s_wr=1, s_wdata=0xDEADBEEF; inst granted in the IDLE cycle after data_data_ok.
REQ-034 Slave returns s_addr_ok and s_data_ok together in REQ -> owner data_ok in that cycle, busy low the next cycle.
REQ-035 Slave holds s_addr_ok=0 for 5 cycles -> s_req and s_addr stay stable for all 5 cycles, no addr_ok/data_ok pulses.
REQ-036 resetn pulled low during WAIT, then s_data_ok after release -> all outputs 0 during reset, no data_ok after release, state IDLE.
REQ-037 Spurious s_data_ok in IDLE -> no data_ok to either master.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared state encoding, owner IDs and size codes for the SRAM arbiter
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - SRAM-style request/response bus with master and slave views
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  // Side that issues requests
  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  // Side that accepts requests
  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-master fixed-priority arbiter onto one SRAM-style slave
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          resetn,
  sram_arbiter_if.slave  inst,
  sram_arbiter_if.slave  data,
  sram_arbiter_if.master s,
  output logic          busy
);

  localparam int LAT_W = 1 + 1 + 2 + ADDR_W + DATA_W;

  state_t            state_q, state_d;
  logic              grant;
  logic              complete;
  logic [LAT_W-1:0]  lat_d, lat_q;
  logic              owner_d, owner_q;

  logic              lat_req;
  logic              lat_wr;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  assign grant = (state_q == ST_IDLE) && (data.req || inst.req);

  // Slave data_ok only counts while a transaction is actually in flight
  assign complete = ((state_q == ST_REQ) && s.addr_ok && s.data_ok) ||
                    ((state_q == ST_WAIT) && s.data_ok);

  assign {lat_req, lat_wr, lat_size, lat_addr, lat_wdata} = lat_q;

  assign s.wr    = lat_wr;
  assign s.size  = lat_size;
  assign s.addr  = lat_addr;
  assign s.wdata = lat_wdata;

  // Winner selection for the request latch: data master has priority
  always_comb begin
    owner_d = OWN_INST;
    lat_d   = {1'b1, inst.wr, inst.size, inst.addr, inst.wdata};
    if (data.req) begin
      owner_d = OWN_DATA;
      lat_d   = {1'b1, data.wr, data.size, data.addr, data.wdata};
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Request latch: loaded only on a grant, frozen while a transaction is open
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lat_q   <= '0;
      owner_q <= OWN_INST;
    end else if (grant) begin
      lat_q   <= lat_d;
      owner_q <= owner_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant) state_d = ST_REQ;
      ST_REQ:  if (s.addr_ok) state_d = s.data_ok ? ST_IDLE : ST_WAIT;
      ST_WAIT: if (s.data_ok) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic; everything is forced low while reset is asserted
  always_comb begin
    inst.addr_ok = 1'b0;
    data.addr_ok = 1'b0;
    inst.data_ok = 1'b0;
    data.data_ok = 1'b0;
    inst.rdata   = '0;
    data.rdata   = '0;
    s.req        = 1'b0;
    busy         = 1'b0;
    if (resetn) begin
      busy = (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (data.req)      data.addr_ok = 1'b1;
          else if (inst.req) inst.addr_ok = 1'b1;
        end
        ST_REQ:  s.req = lat_req;
        default: ;
      endcase
      if (complete) begin
        if (owner_q == OWN_DATA) begin
          data.data_ok = 1'b1;
          data.rdata   = s.rdata;
        end else begin
          inst.data_ok = 1'b1;
          inst.rdata   = s.rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for the SRAM arbiter
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  logic busy;

  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_bus ();
  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_bus ();
  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_bus ();

  sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .inst   (inst_bus),
    .data   (data_bus),
    .s      (s_bus),
    .busy   (busy)
  );

  typedef struct packed {
    logic        owner;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic masters_idle();
    inst_bus.req = 1'b0; inst_bus.wr = 1'b0; inst_bus.size = SIZE_WORD;
    inst_bus.addr = '0;  inst_bus.wdata = '0;
    data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.size = SIZE_WORD;
    data_bus.addr = '0;  data_bus.wdata = '0;
  endtask

  task automatic slave_idle();
    s_bus.addr_ok = 1'b0; s_bus.data_ok = 1'b0; s_bus.rdata = '0;
  endtask

  task automatic drive_inst(input logic wr, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    inst_bus.req = 1'b1; inst_bus.wr = wr; inst_bus.size = size;
    inst_bus.addr = addr; inst_bus.wdata = wdata;
  endtask

  task automatic drive_data(input logic wr, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    data_bus.req = 1'b1; data_bus.wr = wr; data_bus.size = size;
    data_bus.addr = addr; data_bus.wdata = wdata;
  endtask

  task automatic push_exp(input logic owner, input logic [31:0] rdata);
    exp_t e;
    e.owner = owner;
    e.rdata = rdata;
    sb_q.push_back(e);
  endtask

  // Completion monitor: every data_ok pulse must match the oldest expected completion
  always @(negedge clk) begin : monitor
    exp_t e;
    if (inst_bus.data_ok || data_bus.data_ok) begin
      check_val("sb_pending", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_val("sb_both_ok", 64'(inst_bus.data_ok & data_bus.data_ok), 64'd0);
        check_val("sb_owner", 64'(data_bus.data_ok), 64'(e.owner));
        check_val("sb_rdata", 64'(e.owner ? data_bus.rdata : inst_bus.rdata), 64'(e.rdata));
        check_val("sb_other_rdata", 64'(e.owner ? inst_bus.rdata : data_bus.rdata), 64'd0);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    masters_idle();
    slave_idle();
    inst_bus.req = 1'b1;
    s_bus.data_ok = 1'b1;
    s_bus.rdata = 32'h1234_5678;

    // Reset state: requests present, but every output held low
    sample();
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_sreq", 64'(s_bus.req), 64'd0);
    check_val("rst_addr_ok", 64'({inst_bus.addr_ok, data_bus.addr_ok}), 64'd0);
    check_val("rst_s_fields", {s_bus.wr, s_bus.size, s_bus.addr, s_bus.wdata[27:0]}, 64'd0);
    next_cycle();
    next_cycle();
    masters_idle();
    slave_idle();
    resetn = 1'b1;
    next_cycle();

    // Single instruction read: grant N, s_req N+1, data_ok N+3
    drive_inst(1'b0, SIZE_WORD, 32'hBFC0_0000, 32'h0);
    sample();
    check_val("t1_inst_addr_ok", 64'(inst_bus.addr_ok), 64'd1);
    check_val("t1_data_addr_ok", 64'(data_bus.addr_ok), 64'd0);
    check_val("t1_busy_idle", 64'(busy), 64'd0);
    push_exp(OWN_INST, 32'h3C1D_0001);
    next_cycle();
    masters_idle();
    s_bus.addr_ok = 1'b1;
    sample();
    check_val("t1_sreq", 64'(s_bus.req), 64'd1);
    check_val("t1_saddr", 64'(s_bus.addr), 64'hBFC0_0000);
    check_val("t1_swr", 64'(s_bus.wr), 64'd0);
    check_val("t1_busy", 64'(busy), 64'd1);
    next_cycle();
    s_bus.addr_ok = 1'b0;
    sample();
    check_val("t1_wait_sreq", 64'(s_bus.req), 64'd0);
    check_val("t1_wait_no_ok", 64'(inst_bus.data_ok), 64'd0);
    next_cycle();
    s_bus.data_ok = 1'b1;
    s_bus.rdata = 32'h3C1D_0001;
    sample();
    check_val("t1_data_ok", 64'(inst_bus.data_ok), 64'd1);
    next_cycle();
    slave_idle();
    sample();
    check_val("t1_busy_after", 64'(busy), 64'd0);
    check_val("t1_rdata_zero", 64'(inst_bus.rdata), 64'd0);

    // Both masters request: data write wins, inst granted right after completion
    next_cycle();
    drive_data(1'b1, SIZE_WORD, 32'h8000_1000, 32'hDEAD_BEEF);
    drive_inst(1'b1, SIZE_BYTE, 32'h0040_0003, 32'h0000_00AB);
    sample();
    check_val("t2_data_addr_ok", 64'(data_bus.addr_ok), 64'd1);
    check_val("t2_inst_addr_ok", 64'(inst_bus.addr_ok), 64'd0);
    push_exp(OWN_DATA, 32'h0);
    next_cycle();
    data_bus.req = 1'b0;
    s_bus.addr_ok = 1'b1;
    sample();
    check_val("t2_swr", 64'(s_bus.wr), 64'd1);
    check_val("t2_swdata", 64'(s_bus.wdata), 64'hDEAD_BEEF);
    check_val("t2_saddr", 64'(s_bus.addr), 64'h8000_1000);
    check_val("t2_inst_wait_req", 64'(inst_bus.addr_ok), 64'd0);
    next_cycle();
    s_bus.addr_ok = 1'b0;
    sample();
    check_val("t2_inst_wait_wait", 64'(inst_bus.addr_ok), 64'd0);
    next_cycle();
    s_bus.data_ok = 1'b1;
    sample();
    check_val("t2_data_ok", 64'(data_bus.data_ok), 64'd1);
    check_val("t2_inst_wait_done", 64'(inst_bus.addr_ok), 64'd0);
    next_cycle();
    slave_idle();
    sample();
    check_val("t2_inst_grant", 64'(inst_bus.addr_ok), 64'd1);
    push_exp(OWN_INST, 32'h1111_2222);

    // Slave accepts and completes in the same cycle
    next_cycle();
    masters_idle();
    s_bus.addr_ok = 1'b1;
    s_bus.data_ok = 1'b1;
    s_bus.rdata = 32'h1111_2222;
    sample();
    check_val("t3_ssize", 64'(s_bus.size), 64'(SIZE_BYTE));
    check_val("t3_same_cycle_ok", 64'(inst_bus.data_ok), 64'd1);
    next_cycle();
    slave_idle();
    sample();
    check_val("t3_busy_low", 64'(busy), 64'd0);

    // Slave stalls addr_ok for 5 cycles while master inputs wander
    next_cycle();
    drive_data(1'b0, SIZE_HALF, 32'h1234_5670, 32'h0);
    sample();
    check_val("t4_grant", 64'(data_bus.addr_ok), 64'd1);
    push_exp(OWN_DATA, 32'hA5A5_0001);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      drive_data(1'b1, SIZE_BYTE, 32'hFFFF_0000 + 32'(i), 32'h5555_5555);
      drive_inst(1'b0, SIZE_WORD, 32'h0000_0100, 32'h0);
      sample();
      check_val("t4_stall_sreq", 64'(s_bus.req), 64'd1);
      check_val("t4_stall_saddr", 64'(s_bus.addr), 64'h1234_5670);
      check_val("t4_stall_latch", {s_bus.wr, s_bus.size}, {61'd0, 1'b0, SIZE_HALF});
      check_val("t4_stall_oks", 64'({inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok, data_bus.data_ok}), 64'd0);
    end
    next_cycle();
    masters_idle();
    s_bus.addr_ok = 1'b1;
    s_bus.data_ok = 1'b1;
    s_bus.rdata = 32'hA5A5_0001;
    sample();
    check_val("t4_done", 64'(data_bus.data_ok), 64'd1);
    next_cycle();
    slave_idle();

    // Reset during WAIT abandons the transaction
    drive_inst(1'b0, SIZE_WORD, 32'h0000_0010, 32'h0);
    sample();
    check_val("t5_grant", 64'(inst_bus.addr_ok), 64'd1);
    next_cycle();
    masters_idle();
    s_bus.addr_ok = 1'b1;
    next_cycle();
    s_bus.addr_ok = 1'b0;
    sample();
    check_val("t5_in_wait", 64'({busy, s_bus.req}), 64'b10);
    next_cycle();
    resetn = 1'b0;
    drive_inst(1'b1, SIZE_WORD, 32'h0000_0020, 32'h1);
    drive_data(1'b1, SIZE_WORD, 32'h0000_0030, 32'h2);
    s_bus.data_ok = 1'b1;
    s_bus.rdata = 32'hDEAD_0000;
    sample();
    check_val("t5_rst_ctrl", 64'({busy, s_bus.req, inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok, data_bus.data_ok}), 64'd0);
    check_val("t5_rst_saddr", 64'(s_bus.addr), 64'd0);
    check_val("t5_rst_rdata", {inst_bus.rdata, data_bus.rdata}, 64'd0);
    next_cycle();
    masters_idle();
    resetn = 1'b1;
    sample();
    check_val("t5_late_ok", 64'({inst_bus.data_ok, data_bus.data_ok}), 64'd0);
    check_val("t5_idle", 64'(busy), 64'd0);
    next_cycle();
    slave_idle();

    // Spurious slave responses in IDLE
    s_bus.addr_ok = 1'b1;
    s_bus.data_ok = 1'b1;
    s_bus.rdata = 32'hCAFE_F00D;
    sample();
    check_val("t6_spurious_ok", 64'({inst_bus.data_ok, data_bus.data_ok}), 64'd0);
    check_val("t6_spurious_rdata", {inst_bus.rdata, data_bus.rdata}, 64'd0);
    check_val("t6_sreq", 64'(s_bus.req), 64'd0);
    next_cycle();
    slave_idle();
    next_cycle();

    check_val("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
